// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon-style memory bus between instruction fetch (i_*) and data load/store (d_*).
// Optional build macro ARB_ROUND_ROBIN_EN alternates grants when both ports contend in IDLE.
module mips_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_W-1:0]     i_address,
  output logic                  i_waitrequest,
  output logic [DATA_W-1:0]     i_readdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_W-1:0]     d_address,
  input  logic [DATA_W-1:0]     d_writedata,
  input  logic [DATA_W/8-1:0]   d_byteenable,
  output logic                  d_waitrequest,
  output logic [DATA_W-1:0]     d_readdata,
  output logic [ADDR_W-1:0]     address,
  output logic                  read,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata,
  output logic [DATA_W/8-1:0]   byteenable,
  input  logic                  waitrequest,
  input  logic [DATA_W-1:0]     readdata,
  output logic                  conflict_err
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t state;
  logic   d_req;

  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 when the data port completed the most recent transaction
  logic last_grant_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_d <= 1'b0;
    end else if (state == GNT_I && i_read && !waitrequest) begin
      last_grant_d <= 1'b0;
    end else if (state == GNT_D && d_req && !waitrequest) begin
      last_grant_d <= 1'b1;
    end
  end
`endif

  // Arbitration happens only in IDLE; a grant is held until completion or until the requester drops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      conflict_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
          if (d_req && i_read) begin
            state <= last_grant_d ? GNT_I : GNT_D;
          end else if (d_req) begin
            state <= GNT_D;
          end else if (i_read) begin
            state <= GNT_I;
          end
`else
          if (d_req) begin
            state <= GNT_D;
          end else if (i_read) begin
            state <= GNT_I;
          end
`endif
        end
        GNT_I: begin
          if (!i_read || !waitrequest) begin
            state <= IDLE;
          end
        end
        GNT_D: begin
          if (d_read && d_write) begin
            conflict_err <= 1'b1;
          end
          if (!d_req || !waitrequest) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus mux follows the granted port combinationally; a read/write conflict resolves to read
  always_comb begin
    address       = '0;
    read          = 1'b0;
    write         = 1'b0;
    writedata     = '0;
    byteenable    = '0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    i_readdata    = '0;
    d_readdata    = '0;
    case (state)
      GNT_I: begin
        address       = i_address;
        read          = i_read;
        byteenable    = '1;
        i_waitrequest = waitrequest;
        i_readdata    = readdata;
      end
      GNT_D: begin
        address       = d_address;
        read          = d_read;
        write         = d_write & ~d_read;
        writedata     = d_writedata;
        byteenable    = d_byteenable;
        d_waitrequest = waitrequest;
        d_readdata    = readdata;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Two-port arbiter sharing the single Avalon-style memory bus of mips_cpu_bus between an instruction-fetch requester (i_*) and a data load/store requester (d_*).
- Selects one requester per transaction and forwards its address, control and data to the memory port.
- Returns readdata and a per-port waitrequest to each requester.
- Guarantees that read and write are never driven high together on the memory side.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_read  in  1  instruction-fetch read request
- i_address  in  ADDR_W  fetch address
- i_waitrequest  out  1  fetch stall
- i_readdata  out  DATA_W  fetch data
- d_read  in  1  data read request
- d_write  in  1  data write request
- d_address  in  ADDR_W  data address
- d_writedata  in  DATA_W  store data
- d_byteenable  in  DATA_W/8  store/load lanes
- d_waitrequest  out  1  data stall
- d_readdata  out  DATA_W  load data
- address  out  ADDR_W  memory address
- read  out  1  memory read
- write  out  1  memory write
- writedata  out  DATA_W  memory write data
- byteenable  out  DATA_W/8  memory lanes
- waitrequest  in  1  memory stall
- readdata  in  DATA_W  memory read data
- conflict_err  out  1  sticky: d_read and d_write seen high together

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, read=0, write=0, address=0, writedata=0, byteenable=0, i_waitrequest=1, d_waitrequest=1, conflict_err=0, last_grant=I.
- State machine has three states: IDLE, GNT_I, GNT_D.
- IDLE:
  - All memory outputs are 0. Both waitrequests are 1.
  - If a request is pending, the winner's state is registered at the next edge.
  - No request: stay in IDLE.
- Arbitration (fixed priority): d_read|d_write beats i_read.
- GNT_I: memory outputs mirror the i_* signals.
  - read=i_read, write=0, byteenable all ones.
  - i_waitrequest=waitrequest (combinational). d_waitrequest=1.
- GNT_D: memory outputs mirror the d_* signals. i_waitrequest=1. d_waitrequest=waitrequest.
- Completion: the edge where the state is GNT_x and waitrequest=0.
  - State returns to IDLE and last_grant is set to x.
  - Every transaction therefore takes at least 2 cycles: arbitration, then bus.
  - There is one IDLE turnaround cycle between back-to-back transactions.
- Grant is held while waitrequest=1. Requester inputs are not re-sampled for arbitration mid-transaction.
- If the granted requester drops its request while in GNT_x, the state returns to IDLE at the next edge without completing.
- Read data:
  - i_readdata = readdata in GNT_I, else 0.
  - d_readdata = readdata in GNT_D, else 0.
- Conflict handling:
  - d_read=1 and d_write=1 in GNT_D gives read=1, write=0 (read wins).
  - conflict_err is set at that edge and stays 1 until reset.
- Invariant: ~(read && write) in every cycle.
- Reset mid-transaction: outputs go to reset values immediately (asynchronous). The in-flight transaction is abandoned.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both ports request in IDLE, the port not equal to last_grant wins. A single requester always wins.
- Undefined: fixed data-over-instruction priority; last_grant is unused for arbitration.

Test Plan:
1. Reset check: assert reset mid-cycle, release, hold waitrequest=0, no requests -> read=0, write=0, i_waitrequest=1, d_waitrequest=1, conflict_err=0 on the first edge after reset.
2. Fetch with stall: i_read=1, i_address=0xBFC00000, memory waitrequest high 2 cycles then readdata=0x24020005 -> address=0xBFC00000, read=1 for 3 cycles, i_readdata=0x24020005 with i_waitrequest=0 on the 4th cycle after the request, then IDLE.
3. Simultaneous requests (macro undefined): i_read=1 and d_write=1 (d_address=0x1000, d_writedata=0xDEADBEEF, d_byteenable=4'b0011) -> write serviced first with writedata=0xDEADBEEF, byteenable=0011; fetch granted after the turnaround; i_waitrequest=1 throughout the write.
4. Round robin (ARB_ROUND_ROBIN_EN defined): both ports request continuously for 4 transactions -> grant order D,I,D,I (last_grant=I after reset).
5. Conflict: d_read=1 and d_write=1 together -> read=1, write=0 on the bus, conflict_err=1 and still 1 twenty cycles later.
6. Reset mid-transaction: reset pulsed while in GNT_D with waitrequest=1 -> read=0, write=0, d_waitrequest=1 during the reset pulse; the next request re-arbitrates from IDLE.
